// File: rtl/fwd_select_ctrl_pkg.sv
// Shared constants and the in-flight destination record for the operand-forward selector.
// Select codes name the source that feeds each ALU operand mux.
package fwd_select_ctrl_pkg;

    localparam int FWD_SEL_RF    = 0;
    localparam int FWD_SEL_EXMEM = 1;
    localparam int FWD_SEL_MEMWB = 2;

    localparam int REG_ZERO  = 0;
    localparam int REC_RD_W  = 5;
    localparam int REC_W     = REC_RD_W + 3;

    typedef struct packed {
        logic                valid;
        logic [REC_RD_W-1:0] rd;
        logic                wr_en;
        logic                is_load;
    } fwd_rec_t;

endpackage

// File: rtl/fwd_select_ctrl_hit.sv
// Combinational match of one in-flight record against one source register index.
// Register 0 is hard-wired and never matches.
module fwd_hit_cmp
    import fwd_select_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  fwd_rec_t              rec_i,
    input  logic [REG_ADDR_W-1:0] src_i,
    output logic                  hit_o
);

    assign hit_o = rec_i.valid && rec_i.wr_en && (rec_i.rd == src_i)
                   && (src_i != REG_ADDR_W'(REG_ZERO));

endmodule

// File: rtl/fwd_select_ctrl.sv
// Registered ALU operand-forward selects plus one-bubble load-use stall; selects align with EX.
// Optional FWD_SEL_STATS_EN adds saturating forward/stall event counters.
module fwd_select_ctrl
    import fwd_select_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs,
    input  logic [REG_ADDR_W-1:0] dec_rt,
    input  logic                  dec_uses_rt,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_wr_en,
    input  logic                  dec_is_load,
    input  logic                  flush,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  stall
`ifdef FWD_SEL_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_fwd_cnt,
    output logic [STAT_W-1:0]     stat_stall_cnt
`endif
);

    fwd_rec_t         ex_rec_q, mem_rec_q, ex_rec_d, dec_rec;
    logic [SEL_W-1:0] fwd_a_sel_q, fwd_b_sel_q, fwd_a_sel_d, fwd_b_sel_d;
    logic             hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
    logic             issue;

    fwd_hit_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_hit_ex_rs  (.rec_i(ex_rec_q),  .src_i(dec_rs), .hit_o(hit_ex_rs));
    fwd_hit_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_hit_ex_rt  (.rec_i(ex_rec_q),  .src_i(dec_rt), .hit_o(hit_ex_rt));
    fwd_hit_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_hit_mem_rs (.rec_i(mem_rec_q), .src_i(dec_rs), .hit_o(hit_mem_rs));
    fwd_hit_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_hit_mem_rt (.rec_i(mem_rec_q), .src_i(dec_rt), .hit_o(hit_mem_rt));

    // A load in EX cannot supply its data yet; hold decode one cycle so it forwards from MEM/WB instead.
    assign stall = rst_n && dec_valid && !flush && ex_rec_q.is_load
                   && (hit_ex_rs || (dec_uses_rt && hit_ex_rt));
    assign issue = dec_valid && !stall && !flush;

    always_comb begin
        dec_rec         = '0;
        dec_rec.valid   = 1'b1;
        dec_rec.rd      = dec_rd;
        dec_rec.wr_en   = dec_wr_en;
        dec_rec.is_load = dec_is_load;

        ex_rec_d    = '0;
        fwd_a_sel_d = SEL_W'(FWD_SEL_RF);
        fwd_b_sel_d = SEL_W'(FWD_SEL_RF);
        if (issue) begin
            ex_rec_d = dec_rec;
            if (hit_ex_rs)
                fwd_a_sel_d = SEL_W'(FWD_SEL_EXMEM);
            else if (hit_mem_rs)
                fwd_a_sel_d = SEL_W'(FWD_SEL_MEMWB);
            if (dec_uses_rt) begin
                if (hit_ex_rt)
                    fwd_b_sel_d = SEL_W'(FWD_SEL_EXMEM);
                else if (hit_mem_rt)
                    fwd_b_sel_d = SEL_W'(FWD_SEL_MEMWB);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_rec_q    <= '0;
            mem_rec_q   <= '0;
            fwd_a_sel_q <= '0;
            fwd_b_sel_q <= '0;
        end else begin
            ex_rec_q    <= ex_rec_d;
            mem_rec_q   <= ex_rec_q;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;

`ifdef FWD_SEL_STATS_EN
    logic [STAT_W-1:0] fwd_cnt_q, stall_cnt_q, fwd_cnt_d, stall_cnt_d;

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (((fwd_a_sel_q != '0) || (fwd_b_sel_q != '0)) && (fwd_cnt_q != '1))
            fwd_cnt_d = fwd_cnt_q + 1'b1;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_fwd_cnt   = fwd_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
